pe_wave_start_ctrl: RTL and testbench

//  Run controller for a chain of pass-through PE tiles.
//  - Accepts a run command (length, tile mask) over a valid/ready handshake.
//  - Drives one registered ap_start per tile as a staggered wavefront: tile i starts
//    i cycles after tile 0, matching the one-cycle hop latency per tile.
//  - Every enabled tile receives exactly cmd_len unstalled ap_start cycles; stall and

---
 rtl/pe_ctrl_pkg.sv | 18 +
 rtl/pe_start_window.sv | 27 ++
 rtl/pe_wave_start_ctrl.sv | 94 +++++++++
 tb/tb_pe_wave_start_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE wavefront start controller: state encoding,
// default counter width and the terminal wave count.
package pe_ctrl_pkg;

  localparam int unsigned CNT_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StActive = 2'd1,
    StDone   = 2'd2
  } state_e;

  // Last wave step: the final tile's window has closed, so every ap_start is zero there.
  function automatic logic [32:0] term_count(input logic [31:0] len, input int unsigned num_pe);
    return {1'b0, len} + 33'(num_pe) - 33'd1;
  endfunction

endpackage

// File: rtl/pe_start_window.sv
// Per-tile start window: tile i is enabled while i <= k < i + len, gated by its mask bit.
module pe_start_window #(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic [CNT_WIDTH:0]   k,
  input  logic [CNT_WIDTH-1:0] len,
  input  logic [NUM_PE-1:0]    mask,
  output logic [NUM_PE-1:0]    win
);

  // One extra bit over k so that i + len never wraps.
  localparam int unsigned EW = CNT_WIDTH + 2;

  logic [EW-1:0] k_ext;
  logic [EW-1:0] len_ext;

  always_comb begin
    k_ext   = EW'(k);
    len_ext = EW'(len);
    win     = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      win[i] = mask[i] && (k_ext >= EW'(i)) && (k_ext < (EW'(i) + len_ext));
    end
  end

endmodule

// File: rtl/pe_wave_start_ctrl.sv
// Run controller that drives a staggered ap_start wavefront across a chain of PE tiles,
// with stall, abort and a one-cycle done pulse.
module pe_wave_start_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE    = 4,
  parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_WIDTH-1:0] cmd_len,
  input  logic [NUM_PE-1:0]    cmd_mask,
  input  logic                 stall,
  input  logic                 abort,
  output logic [NUM_PE-1:0]    ap_start,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted
);

  localparam int unsigned KW = CNT_WIDTH + 1;

  state_e               state_q;
  logic [KW-1:0]        k_q;
  logic [CNT_WIDTH-1:0] len_q;
  logic [NUM_PE-1:0]    mask_q;
  logic [NUM_PE-1:0]    win;
  logic                 at_term;

  pe_start_window #(
    .NUM_PE    (NUM_PE),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_window (
    .k    (k_q),
    .len  (len_q),
    .mask (mask_q),
    .win  (win)
  );

  assign at_term   = (33'(k_q) == term_count(32'(len_q), NUM_PE));
  assign cmd_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      len_q    <= '0;
      mask_q   <= '0;
      ap_start <= '0;
      aborted  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          ap_start <= '0;
          if (cmd_valid) begin
            len_q   <= cmd_len;
            mask_q  <= cmd_mask;
            k_q     <= '0;
            aborted <= 1'b0;
            state_q <= (cmd_len != '0) ? StActive : StDone;
          end
        end
        StActive: begin
          if (abort) begin
            ap_start <= '0;
            aborted  <= 1'b1;
            state_q  <= StDone;
          end else if (stall) begin
            ap_start <= '0;
          end else if (at_term) begin
            ap_start <= '0;
            state_q  <= StDone;
          end else begin
            ap_start <= win;
            k_q      <= k_q + KW'(1);
          end
        end
        StDone: begin
          ap_start <= '0;
          state_q  <= StIdle;
        end
        default: begin
          ap_start <= '0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_wave_start_ctrl.sv
// Self-checking bench for pe_wave_start_ctrl: directed scenarios plus random commands,
// stalls and aborts, compared each cycle against a run-level reference model.
module tb_pe_wave_start_ctrl;

  localparam int unsigned NUM_PE    = 4;
  localparam int unsigned CNT_WIDTH = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic [CNT_WIDTH-1:0] cmd_len = '0;
  logic [NUM_PE-1:0]    cmd_mask = '0;
  logic                 stall = 1'b0;
  logic                 abort = 1'b0;
  logic [NUM_PE-1:0]    ap_start;
  logic                 busy;
  logic                 done;
  logic                 aborted;

  always #5 clk = ~clk;

  pe_wave_start_ctrl #(
    .NUM_PE    (NUM_PE),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_len   (cmd_len),
    .cmd_mask  (cmd_mask),
    .stall     (stall),
    .abort     (abort),
    .ap_start  (ap_start),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a run is a sequence of unstalled wave steps. At step s tile i is on
  // when its elapsed time s-i lies in [0, len); the run finishes after len+NUM_PE-1 steps.
  int          m_phase;   // 0 idle, 1 running, 2 done
  int          m_len;
  int          m_step;
  bit [3:0]    m_mask;
  bit [3:0]    m_ap;
  bit          m_aborted;
  int          tile_cnt [NUM_PE];

  task automatic model_reset();
    m_phase   = 0;
    m_len     = 0;
    m_step    = 0;
    m_mask    = '0;
    m_ap      = '0;
    m_aborted = 1'b0;
  endtask

  task automatic model_update();
    int elapsed;
    case (m_phase)
      0: begin
        m_ap = '0;
        if (cmd_valid) begin
          m_len     = int'(cmd_len);
          m_mask    = cmd_mask;
          m_step    = 0;
          m_aborted = 1'b0;
          m_phase   = (m_len == 0) ? 2 : 1;
          for (int i = 0; i < NUM_PE; i++) tile_cnt[i] = 0;
        end
      end
      1: begin
        if (abort) begin
          m_ap      = '0;
          m_aborted = 1'b1;
          m_phase   = 2;
        end else if (stall) begin
          m_ap = '0;
        end else if (m_step == m_len + NUM_PE - 1) begin
          m_ap    = '0;
          m_phase = 2;
        end else begin
          for (int i = 0; i < NUM_PE; i++) begin
            elapsed = m_step - i;
            m_ap[i] = m_mask[i] && (elapsed >= 0) && (elapsed < m_len);
          end
          m_step++;
        end
      end
      default: begin
        m_ap    = '0;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare();
    check_eq("ap_start", 32'(ap_start), 32'(m_ap));
    check_eq("status{ready,busy,done,aborted}", 32'({cmd_ready, busy, done, aborted}),
             32'({m_phase == 0, m_phase != 0, m_phase == 2, m_aborted}));
    for (int i = 0; i < NUM_PE; i++) tile_cnt[i] += int'(ap_start[i]);
    if (m_phase == 2 && !m_aborted) begin
      for (int i = 0; i < NUM_PE; i++) begin
        check_eq($sformatf("tile%0d_total", i), 32'(tile_cnt[i]),
                 32'(m_mask[i] ? m_len : 0));
      end
    end
  endtask

  task automatic cycle(input bit v, input int len, input bit [3:0] m, input bit st,
                       input bit ab);
    cmd_valid = v;
    cmd_len   = CNT_WIDTH'(len);
    cmd_mask  = m;
    stall     = st;
    abort     = ab;
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 4'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int r;
    int len;
    model_reset();
    for (int i = 0; i < NUM_PE; i++) tile_cnt[i] = 0;
    #1;
    check_eq("reset_ap_start", 32'(ap_start), 32'd0);
    check_eq("reset_status", 32'({busy, done, aborted}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Full mask, partial mask, stall on the 2nd/3rd edges, empty run.
    cycle(1'b1, 3, 4'hf, 1'b0, 1'b0); idle(10);
    cycle(1'b1, 3, 4'h5, 1'b0, 1'b0); idle(10);
    cycle(1'b1, 5, 4'hf, 1'b0, 1'b0); idle(1);
    cycle(1'b0, 0, 4'h0, 1'b1, 1'b0); cycle(1'b0, 0, 4'h0, 1'b1, 1'b0); idle(12);
    cycle(1'b1, 0, 4'hf, 1'b0, 1'b0); idle(3);

    // Abort together with stall on the tenth edge; aborted must persist until next accept.
    cycle(1'b1, 100, 4'hf, 1'b0, 1'b0); idle(9);
    cycle(1'b0, 0, 4'h0, 1'b1, 1'b1); idle(5);
    cycle(1'b1, 2, 4'h3, 1'b0, 1'b0); idle(8);

    // Asynchronous reset between edges mid-run, then a short run.
    cycle(1'b1, 20, 4'hf, 1'b0, 1'b0); idle(8);
    #2 reset = 1'b0;
    #1;
    check_eq("midrun_reset_ap_start", 32'(ap_start), 32'd0);
    check_eq("midrun_reset_busy_done", 32'({busy, done}), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b1, 1, 4'hf, 1'b0, 1'b0); idle(8);

    for (int c = 0; c < 3000; c++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) len = 0;
      else if (r == 9) len = int'($urandom_range(20, 60));
      else len = int'($urandom_range(1, 8));
      cycle(1'($urandom_range(0, 1)), len, 4'($urandom), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 49) == 0));
    end
    idle(80);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
